lte_ul_ant_demux: RTL and testbench

Downstream of the uplink path transposer in the `clk` domain. It consumes the 8-slot antenna-TDM stream (32-bit words, `i_ant8_sel` marking slot 0, `i_fram_hd` marking frame start) and drops slots of disabled antennas. It tags each forwarded word with antenna id, start-of-frame and last-in-group, then buffers the words in a FIFO behind a valid/ready handshake. It also reports alignment errors, FIFO overflow and the group count of the previous frame.

---
 rtl/lte_ul_pkg.sv | 15 +
 rtl/lte_ul_sync_fifo.sv | 49 ++++
 rtl/lte_ul_ant_demux.sv | 107 ++++++++++
 tb/tb_lte_ul_ant_demux.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lte_ul_pkg.sv
// lte_ul_pkg: shared constants, tagged word type and mask helper for the uplink antenna demux
package lte_ul_pkg;
  localparam int ANT_NUM = 8;
  localparam int SLOT_W = 3;
  typedef struct packed {
    logic sof;
    logic last;
    logic [SLOT_W-1:0] ant_id;
    logic [31:0] data;
  } ul_ant_word_t;
  function automatic logic [SLOT_W-1:0] hi_bit_idx(input logic [ANT_NUM-1:0] mask);
    hi_bit_idx = '0;
    for (int i = 0; i < ANT_NUM; i++) if (mask[i]) hi_bit_idx = SLOT_W'(i);
  endfunction
endpackage

// File: rtl/lte_ul_sync_fifo.sv
// lte_ul_sync_fifo: single-clock show-ahead FIFO with full/empty and occupancy count
module lte_ul_sync_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     asy_rst_n,
  input  logic                     i_wr,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_rd,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr_ok, rd_ok;
  assign o_full = cnt_q == (AW+1)'(DEPTH);
  assign o_empty = cnt_q == '0;
  assign o_cnt = cnt_q;
  assign o_rdata = mem_q[rptr_q];
  // full is judged on the start-of-cycle occupancy, so a same-cycle pop never rescues a write
  always_comb begin
    wr_ok = i_wr & ~o_full;
    rd_ok = i_rd & ~o_empty;
    wptr_d = wptr_q + AW'(wr_ok);
    rptr_d = rptr_q + AW'(rd_ok);
    cnt_d = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end
  // storage array carries no reset; emptiness is tracked by the pointers
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= i_wdata;
  end
  // pointer and occupancy state
  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/lte_ul_ant_demux.sv
// lte_ul_ant_demux: drops disabled antenna slots from the 8-slot TDM stream, tags and buffers the rest
module lte_ul_ant_demux
  import lte_ul_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GCNT_W = 16
) (
  input  logic                clk,
  input  logic                asy_rst_n,
  input  logic                i_fram_hd,
  input  logic                i_ant8_sel,
  input  logic [31:0]         i_data,
  input  logic                i_data_valid,
  input  logic [ANT_NUM-1:0]  i_ant_en,
  input  logic                i_clr,
  output logic [31:0]         o_data,
  output logic [SLOT_W-1:0]   o_ant_id,
  output logic                o_sof,
  output logic                o_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [GCNT_W-1:0]   o_grp_cnt,
  output logic                o_align_err,
  output logic                o_ovf
);
  logic [SLOT_W-1:0] slot_q, slot_d, exp_slot;
  logic [ANT_NUM-1:0] mask_q, mask_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d, grp_cnt_q, grp_cnt_d;
  logic sel_seen_q, sel_seen_d, pend_q, pend_d, arm_q, arm_d;
  logic align_q, align_d, ovf_q, ovf_d, s1_vld_q, s1_vld_d;
  logic slot0, hd, fwd, sof, pend_eff, arm_eff, fifo_full, fifo_empty;
  ul_ant_word_t s1_q, s1_d, fifo_rdata, head;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  // slot tracking, mask latch, SOF arming, group count and sticky flags for one valid beat
  always_comb begin
    exp_slot = slot_q + 1'b1;
    slot_d = !i_data_valid ? slot_q : i_ant8_sel ? '0 : exp_slot;
    slot0 = i_data_valid && slot_d == '0;
    hd = i_data_valid & i_fram_hd;
    mask_d = slot0 ? i_ant_en : mask_q;
    fwd = i_data_valid && mask_d[slot_d];
    sel_seen_d = sel_seen_q | (i_data_valid & i_ant8_sel);
    pend_eff = pend_q | hd;
    arm_eff = arm_q | (slot0 & pend_eff);
    sof = fwd & arm_eff;
    pend_d = slot0 ? 1'b0 : pend_eff;
    arm_d = arm_eff & ~sof;
    grp_cnt_d = hd ? gcnt_q : grp_cnt_q;
    gcnt_d = hd ? (slot0 ? GCNT_W'(1) : '0) : !slot0 ? gcnt_q : &gcnt_q ? gcnt_q : gcnt_q + 1'b1;
    align_d = (i_data_valid && (i_ant8_sel ? (sel_seen_q && exp_slot != '0) : exp_slot == '0))
              | (align_q & ~i_clr);
    ovf_d = (s1_vld_q & fifo_full) | (ovf_q & ~i_clr);
    s1_vld_d = fwd;
    s1_d = '{sof: sof, last: slot_d == hi_bit_idx(mask_d), ant_id: slot_d, data: i_data};
  end
  // stage-1 register: state plus the tagged word heading into the FIFO
  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      slot_q <= '1;
      mask_q <= '0;
      gcnt_q <= '0;
      grp_cnt_q <= '0;
      sel_seen_q <= 1'b0;
      pend_q <= 1'b0;
      arm_q <= 1'b0;
      align_q <= 1'b0;
      ovf_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_q <= '0;
    end else begin
      slot_q <= slot_d;
      mask_q <= mask_d;
      gcnt_q <= gcnt_d;
      grp_cnt_q <= grp_cnt_d;
      sel_seen_q <= sel_seen_d;
      pend_q <= pend_d;
      arm_q <= arm_d;
      align_q <= align_d;
      ovf_q <= ovf_d;
      s1_vld_q <= s1_vld_d;
      s1_q <= s1_d;
    end
  end
  lte_ul_sync_fifo #(.W($bits(ul_ant_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .asy_rst_n(asy_rst_n),
    .i_wr(s1_vld_q),
    .i_wdata(s1_q),
    .i_rd(o_valid & i_ready),
    .o_rdata(fifo_rdata),
    .o_full(fifo_full),
    .o_empty(fifo_empty),
    .o_cnt(fifo_cnt)
  );
  // head fields read as zero while the FIFO holds nothing
  always_comb begin
    head = fifo_empty ? '0 : fifo_rdata;
  end
  assign o_valid = fifo_cnt != '0;
  assign o_data = head.data;
  assign o_ant_id = head.ant_id;
  assign o_sof = head.sof;
  assign o_last = head.last;
  assign o_grp_cnt = grp_cnt_q;
  assign o_align_err = align_q;
  assign o_ovf = ovf_q;
endmodule

// File: tb/tb_lte_ul_ant_demux.sv
// tb_lte_ul_ant_demux: scoreboard bench for the uplink antenna demux
module tb_lte_ul_ant_demux;
  logic clk = 1'b0, asy_rst_n = 1'b0;
  logic i_fram_hd = 0, i_ant8_sel = 0, i_data_valid = 0, i_clr = 0, i_ready = 1;
  logic [31:0] i_data = '0;
  logic [7:0] i_ant_en = '0;
  logic [31:0] o_data;
  logic [2:0] o_ant_id;
  logic o_sof, o_last, o_valid, o_align_err, o_ovf;
  logic [15:0] o_grp_cnt;
  int n_run = 0, n_fail = 0, cyc = 0, beat_cyc = -1, vld_cyc = -1;
  logic [36:0] exp_q[$];

  lte_ul_ant_demux dut (
    .clk(clk), .asy_rst_n(asy_rst_n), .i_fram_hd(i_fram_hd), .i_ant8_sel(i_ant8_sel),
    .i_data(i_data), .i_data_valid(i_data_valid), .i_ant_en(i_ant_en), .i_clr(i_clr),
    .o_data(o_data), .o_ant_id(o_ant_id), .o_sof(o_sof), .o_last(o_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_grp_cnt(o_grp_cnt),
    .o_align_err(o_align_err), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (asy_rst_n) begin
      if (o_valid && vld_cyc < 0 && beat_cyc >= 0) vld_cyc = cyc;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 64'(o_valid), 64'd0);
        else chk("word", {o_sof, o_last, o_ant_id, o_data}, 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic beat(input logic hd, input logic sel, input logic [7:0] en, input logic [31:0] d,
                      input logic fwd, input logic [2:0] id, input logic sof, input logic last);
    i_data_valid = 1; i_fram_hd = hd; i_ant8_sel = sel; i_ant_en = en; i_data = d;
    if (fwd) exp_q.push_back({sof, last, id, d});
    @(posedge clk); #1;
    i_data_valid = 0; i_fram_hd = 0; i_ant8_sel = 0;
  endtask

  task automatic grp(input logic hd, input logic [7:0] en_a, input logic [7:0] en_b,
                     input logic [7:0] fm, input int base, input logic sof);
    int hi;
    logic pend;
    hi = 0;
    pend = sof;
    for (int k = 0; k < 8; k++) if (fm[k]) hi = k;
    for (int k = 0; k < 8; k++) begin
      beat(hd && k == 0, k == 0, k < 4 ? en_a : en_b, 32'(base + k), fm[k], 3'(k),
           pend && fm[k], fm[k] && k == hi);
      if (fm[k]) pend = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clr_pulse();
    i_clr = 1;
    @(posedge clk); #1;
    i_clr = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_head", {o_sof, o_last, o_ant_id, o_data}, 0);
    chk("rst_flags", {o_grp_cnt, o_align_err, o_ovf}, 0);
    asy_rst_n = 1;
    @(posedge clk); #1;
    beat_cyc = cyc;
    grp(1, 8'hFF, 8'hFF, 8'hFF, 0, 1);
    grp(0, 8'hFF, 8'hFF, 8'hFF, 8, 0);
    grp(0, 8'hFF, 8'hFF, 8'hFF, 16, 0);
    drain();
    chk("latency", 64'(vld_cyc - beat_cyc), 64'd2);
    chk("no_flags", {o_align_err, o_ovf}, 0);
    grp(0, 8'h05, 8'h05, 8'h05, 100, 0);
    grp(0, 8'h05, 8'h80, 8'h05, 200, 0);
    grp(0, 8'h80, 8'h80, 8'h80, 300, 0);
    drain();
    chk("mask_no_err", 64'(o_align_err), 0);
    for (int k = 0; k < 5; k++) beat(0, k == 0, 8'hFF, 32'(400 + k), 1, 3'(k), 0, 0);
    beat(0, 1, 8'hFF, 405, 1, 0, 0, 0);
    chk("align_extra", 64'(o_align_err), 1);
    for (int k = 1; k < 8; k++) beat(0, 0, 8'hFF, 32'(405 + k), 1, 3'(k), 0, k == 7);
    clr_pulse();
    chk("align_clr", 64'(o_align_err), 0);
    beat(0, 0, 8'hFF, 420, 1, 0, 0, 0);
    chk("align_miss", 64'(o_align_err), 1);
    for (int k = 1; k < 8; k++) beat(0, 0, 8'hFF, 32'(420 + k), 1, 3'(k), 0, k == 7);
    clr_pulse();
    chk("align_clr2", 64'(o_align_err), 0);
    drain();
    i_ready = 0;
    for (int k = 0; k < 24; k++)
      beat(0, k % 8 == 0, 8'hFF, 32'(500 + k), k < 16, 3'(k % 8), 0, k % 8 == 7);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_set", 64'(o_ovf), 1);
    chk("stall_valid", 64'(o_valid), 1);
    chk("stall_head", {o_ant_id, o_data}, {3'd0, 32'd500});
    i_ready = 1;
    drain();
    clr_pulse();
    chk("ovf_clr", 64'(o_ovf), 0);
    grp(1, 8'hFF, 8'hFF, 8'hFF, 600, 1);
    for (int g = 1; g < 10; g++) grp(0, 8'hFF, 8'hFF, 8'hFF, 600 + 8 * g, 0);
    grp(1, 8'hFF, 8'hFF, 8'hFF, 700, 1);
    chk("grp_cnt", 64'(o_grp_cnt), 10);
    drain();
    grp(1, 8'h00, 8'h00, 8'h00, 800, 0);
    chk("grp_cnt_one", 64'(o_grp_cnt), 1);
    grp(0, 8'h02, 8'h02, 8'h02, 900, 1);
    drain();
    i_ready = 0;
    for (int k = 0; k < 8; k++) beat(0, k == 0, 8'hFF, 32'(1000 + k), 0, 3'(k), 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(o_valid), 1);
    #2 asy_rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'(o_valid), 0);
    chk("mid_rst_head", {o_sof, o_last, o_ant_id, o_data}, 0);
    chk("mid_rst_flags", {o_grp_cnt, o_align_err, o_ovf}, 0);
    @(posedge clk); #1;
    asy_rst_n = 1;
    i_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(o_valid), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, %0d checks done", n_run);
    $fatal(1);
  end
endmodule
